pipe_hazard_pc_unit: RTL and testbench
======================================

// Module: pipe_hazard_pc_unit
// PURPOSE
//  Owns the program counter and all pipeline-control decisions for the parametrised 4-stage core (IF, ID, EX/MEM, WB).
//  - Generates PC-write, IF/ID hold/flush and ID/EX bubble/flush strobes.
//  - Tracks in-flight register writes in a shift-register scoreboard and stalls ID on read-after-write (RAW) hazards.
//  - Applies WB-resolved branch/jump redirects and squashes younger instructions.
//  - Keeps saturating stall and flush performance counters.
// PARAMETERS
//  ADDR_W    32  PC / redirect-target width
//  REG_AW    6   register-index width (2**REG_AW architectural registers)
//  PC_STEP   1   sequential PC increment
//  RESET_PC  0   PC value loaded on reset
//  WB_LAT    2   slots from ID issue to WB; legal range 1..8 (slot 0 = EX, slot WB_LAT-1 = WB)
//  CNT_W     16  performance-counter width
// PORTS
//  clk               in   1        rising-edge clock
//  rst               in   1        synchronous, active-high reset
//  in_ctrl_stall_ext in   1        global freeze request (e.g. multi-cycle data memory)
//  in_id_valid       in   1        ID stage holds a real instruction
//  in_id_rs          in   REG_AW   ID source register index rs
//  in_id_rt          in   REG_AW   ID source register index rt
//  in_id_uses_rs     in   1        instruction reads rs
//  in_id_uses_rt     in   1        instruction reads rt
//  in_id_regwrt      in   1        instruction writes rd
//  in_id_rd          in   REG_AW   ID destination register index
//  in_redirect       in   1        PCControl taken branch/jump, valid in WB
//  in_redirect_pc    in   ADDR_W   redirect target
//  out_pc            out  ADDR_W   current fetch PC (registered)
//  out_ctrl_pcwrt    out  1        PC advances this cycle
//  out_ctrl_ifid_wrt out  1        IF/ID buffer loads this cycle
//  out_ctrl_ifid_flush out 1       IF/ID loads a NOP
//  out_ctrl_idex_flush out 1       ID/EX loads a NOP (covers both bubble and squash)
//  out_stall_cnt     out  CNT_W    cycles lost to RAW stalls (saturating)
//  out_flush_cnt     out  CNT_W    redirects taken (saturating)
// BEHAVIOUR
//  Reset:
//   - While rst=1: out_pc<=RESET_PC; all scoreboard slots invalid; both counters<=0.
//   - Strobes forced: pcwrt=0, ifid_wrt=1, ifid_flush=1, idex_flush=1.
//  Scoreboard:
//   - Slot k holds {valid, rd}; slots shift k->k+1 each unfrozen cycle and slot WB_LAT-1 retires.
//   - Slot 0 loads {in_id_valid & in_id_regwrt & ~haz & ~redirect, in_id_rd}.
//  RAW hazard:
//   - haz = in_id_valid & OR over all valid slots of (uses_rs & rs==slot.rd | uses_rt & rt==slot.rd).
//   - The WB slot still blocks (register file writes at the edge); the read proceeds the cycle after retirement.
//   - Register index 0 gets no special treatment.
//  Priority (highest first):
//   1. stall_ext: everything holds (PC, slots, counters).
//      - pcwrt=0, ifid_wrt=0, both flushes=0.
//      - A pending redirect is held by the frozen WB stage and taken on the first unfrozen cycle.
//   2. redirect:
//      - PC<=in_redirect_pc, so the next cycle's out_pc is the target; pcwrt=1.
//      - ifid_flush=1, ifid_wrt=1, idex_flush=1.
//      - Slots 0..WB_LAT-2 invalidated; the WB slot retires normally.
//      - flush_cnt++. No stall is counted even if haz=1.
//   3. haz:
//      - pcwrt=0, ifid_wrt=0 (IF/ID holds); idex_flush=1 (bubble); stall_cnt++.
//      - Slots shift with slot 0 invalid.
//   4. normal: PC<=PC+PC_STEP (wraps modulo 2**ADDR_W); pcwrt=1, ifid_wrt=1, flushes=0.
//  Strobes: combinational from current inputs and state.
//  Counters: saturate at 2**CNT_W-1; never wrap.
//  Latency: a redirect in cycle N fetches the target in N+1. A producer issued in cycle N releases a dependent in ID at N+WB_LAT+1.
//  Reset mid-operation (rst=1 at any point): overrides all inputs that cycle, including a simultaneous redirect or stall_ext.
// TESTING (WB_LAT=2 unless noted)
//  - Reset: rst=1 for 2 cycles, release, no hazards.
//    -> out_pc = 0,1,2,3...; pcwrt=1 from the first post-reset cycle; counters 0.
//  - RAW: issue r5 write (regwrt, rd=5), then rs=5 reader in ID.
//    -> 2 stall cycles with idex_flush=1 and PC held; reader issues on cycle 3; stall_cnt=2.
//  - Redirect with hazard: redirect to 0x40 while ID has a hazard.
//    -> next out_pc=0x40; ifid_flush=1; idex_flush=1; EX slot cleared; flush_cnt=1; stall_cnt unchanged.
//  - stall_ext with redirect: stall_ext=1 for 3 cycles while redirect=1.
//    -> PC, slots and counters frozen; redirect taken on the release cycle.
//  - Counter saturation: CNT_W=2, 5 consecutive hazard cycles.
//    -> stall_cnt = 1,2,3,3,3.
//  - PC wrap: ADDR_W=4, PC_STEP=1, PC=15, normal cycle.
//    -> out_pc=0.

Source files
------------

// File: rtl/pipe_hazard_pc_unit_if.sv
// Pipeline-control bundle between the hazard/PC unit and the core datapath.
// The core (master) drives the ID/WB status; the unit (slave) returns the PC and strobes.
interface pipe_hazard_pc_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned REG_AW = 6,
   parameter int unsigned CNT_W  = 16
) ();
   logic              in_ctrl_stall_ext;
   logic              in_id_valid;
   logic [REG_AW-1:0] in_id_rs;
   logic [REG_AW-1:0] in_id_rt;
   logic              in_id_uses_rs;
   logic              in_id_uses_rt;
   logic              in_id_regwrt;
   logic [REG_AW-1:0] in_id_rd;
   logic              in_redirect;
   logic [ADDR_W-1:0] in_redirect_pc;
   logic [ADDR_W-1:0] out_pc;
   logic              out_ctrl_pcwrt;
   logic              out_ctrl_ifid_wrt;
   logic              out_ctrl_ifid_flush;
   logic              out_ctrl_idex_flush;
   logic [CNT_W-1:0]  out_stall_cnt;
   logic [CNT_W-1:0]  out_flush_cnt;

   modport master (
      output in_ctrl_stall_ext, in_id_valid, in_id_rs, in_id_rt, in_id_uses_rs,
             in_id_uses_rt, in_id_regwrt, in_id_rd, in_redirect, in_redirect_pc,
      input  out_pc, out_ctrl_pcwrt, out_ctrl_ifid_wrt, out_ctrl_ifid_flush,
             out_ctrl_idex_flush, out_stall_cnt, out_flush_cnt
   );

   modport slave (
      input  in_ctrl_stall_ext, in_id_valid, in_id_rs, in_id_rt, in_id_uses_rs,
             in_id_uses_rt, in_id_regwrt, in_id_rd, in_redirect, in_redirect_pc,
      output out_pc, out_ctrl_pcwrt, out_ctrl_ifid_wrt, out_ctrl_ifid_flush,
             out_ctrl_idex_flush, out_stall_cnt, out_flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_pc_unit.sv
// PC owner and pipeline-control unit for the 4-stage core.
// A shift-register scoreboard tracks in-flight register writes (slot 0 = EX,
// slot WB_LAT-1 = WB) and stalls ID on RAW hazards; WB-resolved redirects
// reload the PC and squash younger work. Stall/flush counters saturate.
module pipe_hazard_pc_unit #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned REG_AW   = 6,
   parameter int unsigned PC_STEP  = 1,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned WB_LAT   = 2,
   parameter int unsigned CNT_W    = 16
) (
   input logic                  clk,
   input logic                  rst,
   pipe_hazard_pc_unit_if.slave bus
);

   logic [ADDR_W-1:0] pc;
   logic [WB_LAT-1:0] sb_vld;
   logic [REG_AW-1:0] sb_rd [WB_LAT];
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic              haz;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // RAW detect: the WB slot still blocks because the register file writes at the edge
   always_comb begin
      haz = 1'b0;
      for (int k = 0; k < int'(WB_LAT); k++) begin
         if (sb_vld[k] && ((bus.in_id_uses_rs && (bus.in_id_rs == sb_rd[k])) ||
                           (bus.in_id_uses_rt && (bus.in_id_rt == sb_rd[k]))))
            haz = 1'b1;
      end
      haz = haz & bus.in_id_valid;
   end

   // Strobes in priority order: reset, external freeze, redirect, hazard, normal
   always_comb begin
      bus.out_ctrl_pcwrt      = 1'b1;
      bus.out_ctrl_ifid_wrt   = 1'b1;
      bus.out_ctrl_ifid_flush = 1'b0;
      bus.out_ctrl_idex_flush = 1'b0;
      if (rst) begin
         bus.out_ctrl_pcwrt      = 1'b0;
         bus.out_ctrl_ifid_flush = 1'b1;
         bus.out_ctrl_idex_flush = 1'b1;
      end else if (bus.in_ctrl_stall_ext) begin
         bus.out_ctrl_pcwrt    = 1'b0;
         bus.out_ctrl_ifid_wrt = 1'b0;
      end else if (bus.in_redirect) begin
         bus.out_ctrl_ifid_flush = 1'b1;
         bus.out_ctrl_idex_flush = 1'b1;
      end else if (haz) begin
         bus.out_ctrl_pcwrt      = 1'b0;
         bus.out_ctrl_ifid_wrt   = 1'b0;
         bus.out_ctrl_idex_flush = 1'b1;
      end
   end

   // PC, scoreboard valids and counters; a freeze holds everything including a pending redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= ADDR_W'(RESET_PC);
         sb_vld    <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!bus.in_ctrl_stall_ext) begin
         if (bus.in_redirect) begin
            // younger slots are squashed and the WB slot retires, so nothing survives
            pc        <= bus.in_redirect_pc;
            sb_vld    <= '0;
            flush_cnt <= sat_inc(flush_cnt);
         end else begin
            for (int k = 1; k < int'(WB_LAT); k++)
               sb_vld[k] <= sb_vld[k-1];
            if (haz) begin
               sb_vld[0] <= 1'b0;
               stall_cnt <= sat_inc(stall_cnt);
            end else begin
               sb_vld[0] <= bus.in_id_valid & bus.in_id_regwrt;
               pc        <= pc + ADDR_W'(PC_STEP);
            end
         end
      end
   end

   // Destination indices travel with the valids; only the valid bits need reset
   always_ff @(posedge clk) begin
      if (!bus.in_ctrl_stall_ext) begin
         for (int k = 1; k < int'(WB_LAT); k++)
            sb_rd[k] <= sb_rd[k-1];
         sb_rd[0] <= bus.in_id_rd;
      end
   end

   assign bus.out_pc        = pc;
   assign bus.out_stall_cnt = stall_cnt;
   assign bus.out_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_pc_unit.sv
// Scoreboard bench for pipe_hazard_pc_unit. Instance A uses the default
// configuration (WB_LAT=2); instance B uses ADDR_W=4, CNT_W=2, WB_LAT=6 for
// PC wrap and counter saturation. Each directed step drives one cycle and
// queues its hand-computed expectation; the monitor pops and compares mid-cycle.
module tb_pipe_hazard_pc_unit;

   localparam logic [3:0] S_RST = 4'b0111;  // {pcwrt, ifid_wrt, ifid_flush, idex_flush}
   localparam logic [3:0] S_FRZ = 4'b0000;
   localparam logic [3:0] S_RDR = 4'b1111;
   localparam logic [3:0] S_HAZ = 4'b0001;
   localparam logic [3:0] S_NRM = 4'b1100;

   typedef struct {
      int          which;
      string       name;
      logic [31:0] pc;
      logic [3:0]  strb;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_pc_unit_if #(.ADDR_W(32), .REG_AW(6), .CNT_W(16)) bus_a ();
   pipe_hazard_pc_unit_if #(.ADDR_W(4),  .REG_AW(6), .CNT_W(2))  bus_b ();

   pipe_hazard_pc_unit #(.ADDR_W(32), .REG_AW(6), .PC_STEP(1), .RESET_PC(0),
                         .WB_LAT(2), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   pipe_hazard_pc_unit #(.ADDR_W(4), .REG_AW(6), .PC_STEP(1), .RESET_PC(0),
                         .WB_LAT(6), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   // One cycle of stimulus on the selected instance (the other idles) plus its expectation
   task automatic step(input int which, input string nm, input logic r, input logic st,
                       input logic v, input logic [5:0] rs, input logic urs,
                       input logic [5:0] rt, input logic urt, input logic rw,
                       input logic [5:0] rd, input logic rdr, input logic [31:0] rpc,
                       input logic [31:0] epc, input logic [3:0] es,
                       input logic [15:0] esc, input logic [15:0] efc);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      bus_a.in_ctrl_stall_ext = (which == 0) ? st  : 1'b0;
      bus_a.in_id_valid       = (which == 0) ? v   : 1'b0;
      bus_a.in_id_rs          = rs;
      bus_a.in_id_rt          = rt;
      bus_a.in_id_uses_rs     = (which == 0) ? urs : 1'b0;
      bus_a.in_id_uses_rt     = (which == 0) ? urt : 1'b0;
      bus_a.in_id_regwrt      = (which == 0) ? rw  : 1'b0;
      bus_a.in_id_rd          = rd;
      bus_a.in_redirect       = (which == 0) ? rdr : 1'b0;
      bus_a.in_redirect_pc    = rpc;
      bus_b.in_ctrl_stall_ext = (which == 1) ? st  : 1'b0;
      bus_b.in_id_valid       = (which == 1) ? v   : 1'b0;
      bus_b.in_id_rs          = rs;
      bus_b.in_id_rt          = rt;
      bus_b.in_id_uses_rs     = (which == 1) ? urs : 1'b0;
      bus_b.in_id_uses_rt     = (which == 1) ? urt : 1'b0;
      bus_b.in_id_regwrt      = (which == 1) ? rw  : 1'b0;
      bus_b.in_id_rd          = rd;
      bus_b.in_redirect       = (which == 1) ? rdr : 1'b0;
      bus_b.in_redirect_pc    = rpc[3:0];
      e.which = which; e.name = nm; e.pc = epc; e.strb = es; e.sc = esc; e.fc = efc;
      q.push_back(e);
   endtask

   // Monitor: outputs are presented every cycle; compare whenever an expectation is queued
   initial begin
      exp_t        e;
      logic [31:0] apc;
      logic [3:0]  as;
      logic [15:0] asc, afc;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.which == 0) begin
               apc = bus_a.out_pc;
               as  = {bus_a.out_ctrl_pcwrt, bus_a.out_ctrl_ifid_wrt,
                      bus_a.out_ctrl_ifid_flush, bus_a.out_ctrl_idex_flush};
               asc = bus_a.out_stall_cnt;
               afc = bus_a.out_flush_cnt;
            end else begin
               apc = {28'd0, bus_b.out_pc};
               as  = {bus_b.out_ctrl_pcwrt, bus_b.out_ctrl_ifid_wrt,
                      bus_b.out_ctrl_ifid_flush, bus_b.out_ctrl_idex_flush};
               asc = {14'd0, bus_b.out_stall_cnt};
               afc = {14'd0, bus_b.out_flush_cnt};
            end
            checks++;
            if (apc !== e.pc || as !== e.strb || asc !== e.sc || afc !== e.fc) begin
               errors++;
               $display("FAIL %s: got pc=%h strb=%b stall=%0d flush=%0d, want pc=%h strb=%b stall=%0d flush=%0d",
                        e.name, apc, as, asc, afc, e.pc, e.strb, e.sc, e.fc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus_a.in_ctrl_stall_ext = 1'b0; bus_a.in_id_valid = 1'b0; bus_a.in_id_rs = '0;
      bus_a.in_id_rt = '0; bus_a.in_id_uses_rs = 1'b0; bus_a.in_id_uses_rt = 1'b0;
      bus_a.in_id_regwrt = 1'b0; bus_a.in_id_rd = '0; bus_a.in_redirect = 1'b0;
      bus_a.in_redirect_pc = '0;
      bus_b.in_ctrl_stall_ext = 1'b0; bus_b.in_id_valid = 1'b0; bus_b.in_id_rs = '0;
      bus_b.in_id_rt = '0; bus_b.in_id_uses_rs = 1'b0; bus_b.in_id_uses_rt = 1'b0;
      bus_b.in_id_regwrt = 1'b0; bus_b.in_id_rd = '0; bus_b.in_redirect = 1'b0;
      bus_b.in_redirect_pc = '0;

      //        which name          rst st vld rs urs rt urt rw rd rdr rpc    | pc     strb   stall flush
      step(0, "reset0",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,     S_RST, 0, 0);
      step(0, "reset1",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,     S_RST, 0, 0);
      step(0, "seq_pc0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,     S_NRM, 0, 0);
      step(0, "seq_pc1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1,     S_NRM, 0, 0);
      step(0, "seq_pc2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      2,     S_NRM, 0, 0);
      step(0, "seq_pc3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      3,     S_NRM, 0, 0);
      // RAW: r5 producer, then rs=5 reader stalls in EX and WB slots
      step(0, "raw_prod",    0, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0,      4,     S_NRM, 0, 0);
      step(0, "raw_stall1",  0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0,      5,     S_HAZ, 0, 0);
      step(0, "raw_stall2",  0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0,      5,     S_HAZ, 1, 0);
      step(0, "raw_issue",   0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0,      5,     S_NRM, 2, 0);
      // Redirect while ID has an rt hazard and itself writes r9
      step(0, "rdr_prod",    0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0,      6,     S_NRM, 2, 0);
      step(0, "rdr_haz",     0, 0, 1, 0, 0, 7, 1, 1, 9, 1, 32'h40, 7,     S_RDR, 2, 0);
      step(0, "rdr_target",  0, 0, 1, 9, 1, 7, 1, 0, 0, 0, 0,      32'h40, S_NRM, 2, 1);
      // External freeze with a pending redirect, then release
      step(0, "frz_prod",    0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0,      32'h41, S_NRM, 2, 1);
      step(0, "frz1",        0, 1, 1, 3, 1, 0, 0, 0, 0, 1, 32'h80, 32'h42, S_FRZ, 2, 1);
      step(0, "frz2",        0, 1, 1, 3, 1, 0, 0, 0, 0, 1, 32'h80, 32'h42, S_FRZ, 2, 1);
      step(0, "frz3",        0, 1, 1, 3, 1, 0, 0, 0, 0, 1, 32'h80, 32'h42, S_FRZ, 2, 1);
      step(0, "frz_release", 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 32'h80, 32'h42, S_RDR, 2, 1);
      step(0, "frz_target",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      32'h80, S_NRM, 2, 2);
      // Reset overriding a simultaneous freeze and redirect
      step(0, "rst_override",1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 32'h99, 32'h81, S_RST, 2, 2);
      step(0, "rst_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,     S_NRM, 0, 0);
      step(0, "rst_again",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1,     S_RST, 0, 0);
      // Instance B: 6 hazard cycles saturate a 2-bit counter, then 4-bit PC wrap
      step(1, "b_reset",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0,     S_RST, 0, 0);
      step(1, "b_prod",      0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0,      0,     S_NRM, 0, 0);
      step(1, "b_sat0",      0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,      1,     S_HAZ, 0, 0);
      step(1, "b_sat1",      0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,      1,     S_HAZ, 1, 0);
      step(1, "b_sat2",      0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,      1,     S_HAZ, 2, 0);
      step(1, "b_sat3",      0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,      1,     S_HAZ, 3, 0);
      step(1, "b_sat4",      0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,      1,     S_HAZ, 3, 0);
      step(1, "b_sat5",      0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,      1,     S_HAZ, 3, 0);
      step(1, "b_issue",     0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,      1,     S_NRM, 3, 0);
      for (int i = 0; i < 16; i++)
         step(1, "b_wrap",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'((2 + i) % 16), S_NRM, 3, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
